// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALUOp codes, control-bit layout
// and the combinational instruction decoder used by the ID stage.
package mips_pkg;

    localparam int CTRL_W = 12;

    localparam int CTRL_REGDST    = 0;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_MEMREAD   = 3;
    localparam int CTRL_MEMTOREG  = 4;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_MEMWRITE  = 9;
    localparam int CTRL_ALUSRC    = 10;
    localparam int CTRL_REGWRITE  = 11;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;
    localparam logic [5:0] FN_SGT = 6'd55;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_BNE = 4'b1001;
    localparam logic [3:0] ALU_SGT = 4'b1010;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
        logic  uses_rs;
        logic  uses_rt;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [3:0] alu;
        d   = '0;
        alu = ALU_AND;
        case (instr[31:26])
            OP_RTYPE: begin
                // Shifts keep uses_rs set: over-stalling is harmless, under-stalling is not.
                d.uses_rs               = 1'b1;
                d.uses_rt               = 1'b1;
                d.ctrl[CTRL_REGWRITE]   = 1'b1;
                d.ctrl[CTRL_REGDST]     = 1'b1;
                case (instr[5:0])
                    FN_ADD:  alu = ALU_ADD;
                    FN_AND:  alu = ALU_AND;
                    FN_SUB:  alu = ALU_SUB;
                    FN_OR:   alu = ALU_OR;
                    FN_SLL:  alu = ALU_SLL;
                    FN_SRL:  alu = ALU_SRL;
                    FN_SRA:  alu = ALU_SRA;
                    FN_SLT:  alu = ALU_SLT;
                    FN_SGT:  alu = ALU_SGT;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_BEQ: begin
                d.uses_rs = 1'b1; d.uses_rt = 1'b1;
                d.ctrl[CTRL_BRANCH] = 1'b1;
                alu = ALU_SUB;
            end
            OP_BNE: begin
                d.uses_rs = 1'b1; d.uses_rt = 1'b1;
                d.ctrl[CTRL_BRANCH] = 1'b1;
                alu = ALU_BNE;
            end
            OP_LW: begin
                d.uses_rs = 1'b1;
                d.ctrl[CTRL_REGWRITE] = 1'b1; d.ctrl[CTRL_ALUSRC]   = 1'b1;
                d.ctrl[CTRL_MEMREAD]  = 1'b1; d.ctrl[CTRL_MEMTOREG] = 1'b1;
                alu = ALU_ADD;
            end
            OP_SW: begin
                d.uses_rs = 1'b1; d.uses_rt = 1'b1;
                d.ctrl[CTRL_ALUSRC] = 1'b1; d.ctrl[CTRL_MEMWRITE] = 1'b1;
                alu = ALU_ADD;
            end
            OP_ADDI: begin
                d.uses_rs = 1'b1;
                d.ctrl[CTRL_REGWRITE] = 1'b1; d.ctrl[CTRL_ALUSRC] = 1'b1;
                alu = ALU_ADD;
            end
            OP_J:    d.ctrl[CTRL_JUMP] = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.ctrl    = '0;
            d.uses_rs = 1'b0;
            d.uses_rt = 1'b0;
        end else begin
            d.ctrl[CTRL_ALUOP_LSB +: 4] = alu;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Bundle of fetch handshake, writeback port and ID/EX outputs of decode_pipe.
// master = surrounding pipeline, slave = decode stage.
interface decode_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import mips_pkg::*;

    logic              In_Valid;
    logic              In_Ready;
    logic [31:0]       Instruction;
    logic              Flush;
    logic              WB_En;
    logic [REG_AW-1:0] WB_Reg;
    logic [DATA_W-1:0] WB_Data;
    logic              Out_Valid;
    ctrl_t             Out_Ctrl;
    logic [DATA_W-1:0] Out_ReadData1;
    logic [DATA_W-1:0] Out_ReadData2;
    logic [REG_AW-1:0] Out_WriteReg;
    logic [REG_AW-1:0] Out_Rs;
    logic [REG_AW-1:0] Out_Rt;
    logic [4:0]        Out_Shamt;
    logic [DATA_W-1:0] Out_Imm;
    logic [25:0]       Out_JTarget;
    logic              Out_Illegal;
    logic              Stall;

    modport master (
        output In_Valid, Instruction, Flush, WB_En, WB_Reg, WB_Data,
        input  In_Ready, Out_Valid, Out_Ctrl, Out_ReadData1, Out_ReadData2, Out_WriteReg,
               Out_Rs, Out_Rt, Out_Shamt, Out_Imm, Out_JTarget, Out_Illegal, Stall
    );

    modport slave (
        input  In_Valid, Instruction, Flush, WB_En, WB_Reg, WB_Data,
        output In_Ready, Out_Valid, Out_Ctrl, Out_ReadData1, Out_ReadData2, Out_WriteReg,
               Out_Rs, Out_Rt, Out_Shamt, Out_Imm, Out_JTarget, Out_Illegal, Stall
    );

endinterface

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port, write-through
// bypass and asynchronous clear; optional hard-wired zero register.
module regfile_bypass #(
    parameter int DATA_W    = 32,
    parameter int REG_CNT   = 32,
    parameter bit ZERO_HARD = 1'b1,
    localparam int REG_AW   = $clog2(REG_CNT)
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        we,
    input  logic [REG_AW-1:0]           wa,
    input  logic [DATA_W-1:0]           wd,
    input  logic [1:0][REG_AW-1:0]      ra,
    output logic [1:0][DATA_W-1:0]      rd
);

    logic [DATA_W-1:0] regs_reg [REG_CNT];
    logic              wr_ok;

    assign wr_ok = we && !(ZERO_HARD && (wa == '0));

    // Async clear forces flops rather than block RAM; the reset-clear behaviour needs it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_reg[wa] <= wd;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic is_zero;
            assign is_zero = ZERO_HARD && (ra[gi] == '0);
            assign rd[gi]  = is_zero                  ? '0 :
                             (we && (wa == ra[gi]))   ? wd :
                                                        regs_reg[ra[gi]];
        end
    endgenerate

endmodule

// File: rtl/decode_pipe.sv
// Pipelined MIPS decode stage: register read with bypass, control decode,
// load-use hazard detection and the registered ID/EX boundary.
module decode_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_CNT   = 32,
    parameter bit ZERO_HARD = 1'b1,
    localparam int REG_AW   = $clog2(REG_CNT)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    decode_pipe_if.slave  bus
);

    decode_t                   dec;
    logic [REG_AW-1:0]         rs_idx;
    logic [REG_AW-1:0]         rt_idx;
    logic [REG_AW-1:0]         rd_idx;
    logic [REG_AW-1:0]         wreg_next;
    logic [1:0][REG_AW-1:0]    rf_ra;
    logic [1:0][DATA_W-1:0]    rf_rd;
    logic                      stall;
    logic                      load;

    logic                      valid_reg;
    ctrl_t                     ctrl_reg;
    logic [DATA_W-1:0]         rd1_reg;
    logic [DATA_W-1:0]         rd2_reg;
    logic [REG_AW-1:0]         wreg_reg;
    logic [REG_AW-1:0]         rs_reg;
    logic [REG_AW-1:0]         rt_reg;
    logic [4:0]                shamt_reg;
    logic [DATA_W-1:0]         imm_reg;
    logic [25:0]               jt_reg;
    logic                      illegal_reg;

    assign dec       = decode_instr(bus.Instruction);
    assign rs_idx    = bus.Instruction[21 +: REG_AW];
    assign rt_idx    = bus.Instruction[16 +: REG_AW];
    assign rd_idx    = bus.Instruction[11 +: REG_AW];
    assign wreg_next = dec.ctrl[CTRL_REGDST] ? rd_idx : rt_idx;
    assign rf_ra     = {rt_idx, rs_idx};

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .REG_CNT   (REG_CNT),
        .ZERO_HARD (ZERO_HARD)
    ) u_rf (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .we    (bus.WB_En),
        .wa    (bus.WB_Reg),
        .wd    (bus.WB_Data),
        .ra    (rf_ra),
        .rd    (rf_rd)
    );

    // A load in ID/EX whose destination feeds the incoming instruction costs one bubble.
    assign stall = valid_reg && ctrl_reg[CTRL_MEMREAD] && (wreg_reg != '0) &&
                   ((dec.uses_rs && (wreg_reg == rs_idx)) ||
                    (dec.uses_rt && (wreg_reg == rt_idx))) &&
                   bus.In_Valid;
    assign load  = bus.In_Valid && !stall && !bus.Flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            rd1_reg     <= '0;
            rd2_reg     <= '0;
            wreg_reg    <= '0;
            rs_reg      <= '0;
            rt_reg      <= '0;
            shamt_reg   <= '0;
            imm_reg     <= '0;
            jt_reg      <= '0;
            illegal_reg <= 1'b0;
        end else begin
            valid_reg <= (bus.Flush || stall) ? 1'b0 : bus.In_Valid;
            if (load) begin
                ctrl_reg    <= dec.ctrl;
                illegal_reg <= dec.illegal;
                rd1_reg     <= rf_rd[0];
                rd2_reg     <= rf_rd[1];
                wreg_reg    <= wreg_next;
                rs_reg      <= rs_idx;
                rt_reg      <= rt_idx;
                shamt_reg   <= bus.Instruction[10:6];
                imm_reg     <= {{(DATA_W-16){bus.Instruction[15]}}, bus.Instruction[15:0]};
                jt_reg      <= bus.Instruction[25:0];
            end else begin
                // Zeroed control keeps a bubble from re-triggering the hazard or writing state.
                ctrl_reg    <= '0;
                illegal_reg <= 1'b0;
            end
        end
    end

    assign bus.Stall         = stall;
    assign bus.In_Ready      = !stall;
    assign bus.Out_Valid     = valid_reg;
    assign bus.Out_Ctrl      = ctrl_reg;
    assign bus.Out_ReadData1 = rd1_reg;
    assign bus.Out_ReadData2 = rd2_reg;
    assign bus.Out_WriteReg  = wreg_reg;
    assign bus.Out_Rs        = rs_reg;
    assign bus.Out_Rt        = rt_reg;
    assign bus.Out_Shamt     = shamt_reg;
    assign bus.Out_Imm       = imm_reg;
    assign bus.Out_JTarget   = jt_reg;
    assign bus.Out_Illegal   = illegal_reg;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe; a second instance with ZERO_HARD=0
// covers the writable register 0.
module tb_decode_pipe;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   errors;

    decode_pipe_if #(.DATA_W(32), .REG_AW(5)) bus  ();
    decode_pipe_if #(.DATA_W(32), .REG_AW(5)) busz ();

    decode_pipe #(.DATA_W(32), .REG_CNT(32), .ZERO_HARD(1'b1)) dut (
        .Clk (Clk), .Rst_n (Rst_n), .bus (bus)
    );
    decode_pipe #(.DATA_W(32), .REG_CNT(32), .ZERO_HARD(1'b0)) dut_z0 (
        .Clk (Clk), .Rst_n (Rst_n), .bus (busz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
        rtype = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
        itype = {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.In_Valid = 1'b0; bus.Flush = 1'b0; bus.WB_En = 1'b0;
        bus.WB_Reg = '0; bus.WB_Data = '0; bus.Instruction = '0;
        busz.In_Valid = 1'b0; busz.Flush = 1'b0; busz.WB_En = 1'b0;
        busz.WB_Reg = '0; busz.WB_Data = '0; busz.Instruction = '0;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.In_Valid = 1'b1; bus.Instruction = instr;
    endtask

    task automatic test_reset();
        checks++; if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.Out_Valid); end
        checks++; if (bus.Out_Ctrl !== 12'h000) begin errors++; $display("FAIL rst_ctrl: got %h want 000", bus.Out_Ctrl); end
        checks++; if (bus.Out_Illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %0b want 0", bus.Out_Illegal); end
        checks++; if (bus.In_Ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", bus.In_Ready); end
        Rst_n = 1'b1;
        tick();
        // Run something, then pull reset asynchronously mid-cycle.
        bus.WB_En = 1'b1; bus.WB_Reg = 5'd1; bus.WB_Data = 32'd99;
        issue(rtype(1, 2, 3, 0, 32));
        tick();
        $display("txn reset: ADD r3,r1,r2 accepted, async reset mid-cycle");
        idle();
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", bus.Out_Valid); end
        checks++; if (bus.Out_ReadData1 !== 32'd0) begin errors++; $display("FAIL rst_mid_rd1: got %h want 0", bus.Out_ReadData1); end
        #1 Rst_n = 1'b1;
        tick();
        issue(rtype(1, 2, 3, 0, 32));
        tick();
        checks++; if (bus.Out_ReadData1 !== 32'd0) begin errors++; $display("FAIL rst_regclr: got %h want 0", bus.Out_ReadData1); end
        idle();
    endtask

    task automatic test_writeback();
        bus.WB_En = 1'b1; bus.WB_Reg = 5'd1; bus.WB_Data = 32'd8;
        tick();
        bus.WB_Reg = 5'd2; bus.WB_Data = 32'd15;
        tick();
        bus.WB_En = 1'b0;
        issue(rtype(1, 2, 3, 0, 32));
        tick();
        $display("txn writeback: R1=8 R2=15 then ADD r3,r1,r2");
        checks++; if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", bus.Out_Valid); end
        checks++; if (bus.Out_Ctrl !== 12'b100_0010_00001) begin errors++; $display("FAIL add_ctrl: got %h want 841", bus.Out_Ctrl); end
        checks++; if (bus.Out_ReadData1 !== 32'd8) begin errors++; $display("FAIL add_rd1: got %0d want 8", bus.Out_ReadData1); end
        checks++; if (bus.Out_ReadData2 !== 32'd15) begin errors++; $display("FAIL add_rd2: got %0d want 15", bus.Out_ReadData2); end
        checks++; if (bus.Out_WriteReg !== 5'd3) begin errors++; $display("FAIL add_wreg: got %0d want 3", bus.Out_WriteReg); end
        checks++; if (bus.Out_Rs !== 5'd1 || bus.Out_Rt !== 5'd2) begin errors++; $display("FAIL add_rsrt: got %0d/%0d want 1/2", bus.Out_Rs, bus.Out_Rt); end
        idle();
    endtask

    task automatic test_zero_reg();
        // Same-cycle write to R0 must not bypass when R0 is hard-wired.
        bus.WB_En = 1'b1; bus.WB_Reg = 5'd0; bus.WB_Data = 32'hDEAD;
        issue(rtype(0, 0, 3, 0, 32));
        tick();
        checks++; if (bus.Out_ReadData1 !== 32'd0) begin errors++; $display("FAIL zero_bypass: got %h want 0", bus.Out_ReadData1); end
        bus.WB_En = 1'b0;
        tick();
        checks++; if (bus.Out_ReadData1 !== 32'd0) begin errors++; $display("FAIL zero_stored: got %h want 0", bus.Out_ReadData1); end
        idle();
        busz.WB_En = 1'b1; busz.WB_Reg = 5'd0; busz.WB_Data = 32'hDEAD;
        tick();
        busz.WB_En = 1'b0;
        busz.In_Valid = 1'b1; busz.Instruction = rtype(0, 0, 3, 0, 32);
        tick();
        $display("txn zero_reg: WB R0=DEAD, read rs=0 on both instances");
        checks++; if (busz.Out_ReadData1 !== 32'hDEAD) begin errors++; $display("FAIL zero_soft: got %h want dead", busz.Out_ReadData1); end
        idle();
    endtask

    task automatic test_bypass();
        bus.WB_En = 1'b1; bus.WB_Reg = 5'd5; bus.WB_Data = 32'h1234;
        issue(rtype(5, 6, 4, 0, 34));
        tick();
        $display("txn bypass: SUB r4,r5,r6 with WB R5=1234 same cycle");
        checks++; if (bus.Out_ReadData1 !== 32'h1234) begin errors++; $display("FAIL byp_rd1: got %h want 1234", bus.Out_ReadData1); end
        checks++; if (bus.Out_ReadData2 !== 32'h0) begin errors++; $display("FAIL byp_rd2: got %h want 0", bus.Out_ReadData2); end
        checks++; if (bus.Out_Ctrl !== 12'h821) begin errors++; $display("FAIL sub_ctrl: got %h want 821", bus.Out_Ctrl); end
        bus.WB_En = 1'b0;
        issue(rtype(0, 5, 9, 0, 32));
        tick();
        checks++; if (bus.Out_ReadData2 !== 32'h1234) begin errors++; $display("FAIL byp_stored: got %h want 1234", bus.Out_ReadData2); end
        idle();
    endtask

    task automatic test_load_use();
        issue(itype(35, 1, 7, 16'd4));
        #1;
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL lw_nostall: got %0b want 0", bus.Stall); end
        tick();
        $display("txn load_use: LW r7,4(r1) then ADD r8,r7,r2");
        checks++; if (bus.Out_Ctrl !== 12'hC58) begin errors++; $display("FAIL lw_ctrl: got %h want c58", bus.Out_Ctrl); end
        checks++; if (bus.Out_WriteReg !== 5'd7 || bus.Out_Imm !== 32'd4) begin errors++; $display("FAIL lw_fields: got %0d/%h want 7/4", bus.Out_WriteReg, bus.Out_Imm); end
        issue(rtype(7, 2, 8, 0, 32));
        #1;
        checks++; if (bus.Stall !== 1'b1 || bus.In_Ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %0b/%0b want 1/0", bus.Stall, bus.In_Ready); end
        tick();
        checks++; if (bus.Out_Valid !== 1'b0 || bus.Out_Ctrl !== 12'h000) begin errors++; $display("FAIL lu_bubble: got %0b/%h want 0/000", bus.Out_Valid, bus.Out_Ctrl); end
        checks++; if (bus.Stall !== 1'b0 || bus.In_Ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %0b/%0b want 0/1", bus.Stall, bus.In_Ready); end
        tick();
        checks++; if (bus.Out_Valid !== 1'b1 || bus.Out_WriteReg !== 5'd8 || bus.Out_Rs !== 5'd7) begin errors++; $display("FAIL lu_add: got v%0b wr%0d rs%0d want v1 wr8 rs7", bus.Out_Valid, bus.Out_WriteReg, bus.Out_Rs); end
        checks++; if (bus.Out_ReadData2 !== 32'd15) begin errors++; $display("FAIL lu_add_rd2: got %0d want 15", bus.Out_ReadData2); end
        // Load to r0 never creates a hazard.
        issue(itype(35, 1, 0, 16'd0));
        tick();
        issue(itype(43, 0, 7, 16'd0));
        #1;
        $display("txn load_use: LW r0,0(r1) then SW r7,0(r0)");
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL lw0_stall: got %0b want 0", bus.Stall); end
        tick();
        checks++; if (bus.Out_Valid !== 1'b1 || bus.Out_Ctrl !== 12'h640) begin errors++; $display("FAIL sw_ctrl: got %0b/%h want 1/640", bus.Out_Valid, bus.Out_Ctrl); end
        idle();
    endtask

    task automatic test_flush();
        issue(itype(35, 1, 7, 16'd0));
        tick();
        issue(itype(4, 7, 2, 16'd3));
        bus.Flush = 1'b1;
        #1;
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL fl_stall: got %0b want 1", bus.Stall); end
        tick();
        $display("txn flush: BEQ r7,r2 with Flush during load-use stall");
        checks++; if (bus.Out_Valid !== 1'b0 || bus.Out_Ctrl !== 12'h000) begin errors++; $display("FAIL fl_valid: got %0b/%h want 0/000", bus.Out_Valid, bus.Out_Ctrl); end
        bus.Flush = 1'b0;
        tick();
        checks++; if (bus.Out_Valid !== 1'b1 || bus.Out_Ctrl !== 12'h024) begin errors++; $display("FAIL beq_ctrl: got %0b/%h want 1/024", bus.Out_Valid, bus.Out_Ctrl); end
        issue(rtype(1, 2, 3, 0, 32));
        bus.Flush = 1'b1;
        tick();
        checks++; if (bus.Out_Valid !== 1'b0 || bus.Out_Ctrl !== 12'h000) begin errors++; $display("FAIL fl_nostall: got %0b/%h want 0/000", bus.Out_Valid, bus.Out_Ctrl); end
        idle();
    endtask

    task automatic test_imm_j_illegal();
        issue(itype(8, 1, 10, 16'hFFFC));
        tick();
        $display("txn imm: ADDI r10,r1,-4 / J / opcode 63 / BNE");
        checks++; if (bus.Out_Imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm: got %h want fffffffc", bus.Out_Imm); end
        checks++; if (bus.Out_Ctrl !== 12'hC40 || bus.Out_WriteReg !== 5'd10) begin errors++; $display("FAIL addi_ctrl: got %h/%0d want c40/10", bus.Out_Ctrl, bus.Out_WriteReg); end
        issue({6'd2, 26'h1234567});
        tick();
        checks++; if (bus.Out_Ctrl !== 12'h002 || bus.Out_JTarget !== 26'h1234567) begin errors++; $display("FAIL j: got %h/%h want 002/1234567", bus.Out_Ctrl, bus.Out_JTarget); end
        issue({6'd63, 26'h0});
        tick();
        checks++; if (bus.Out_Valid !== 1'b1 || bus.Out_Ctrl !== 12'h000 || bus.Out_Illegal !== 1'b1) begin errors++; $display("FAIL op63: got v%0b c%h i%0b want v1 c000 i1", bus.Out_Valid, bus.Out_Ctrl, bus.Out_Illegal); end
        issue(itype(5, 1, 2, 16'd8));
        tick();
        checks++; if (bus.Out_Ctrl !== 12'h124 || bus.Out_Illegal !== 1'b0) begin errors++; $display("FAIL bne: got %h/%0b want 124/0", bus.Out_Ctrl, bus.Out_Illegal); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fn  [8];
        logic [11:0] exp [8];
        fn  = '{6'd36, 6'd37, 6'd0,  6'd2,  6'd3,  6'd42, 6'd55, 6'd1};
        exp = '{12'h801, 12'h861, 12'h881, 12'h8A1, 12'h8C1, 12'h901, 12'h941, 12'h000};
        for (int i = 0; i < 8; i++) begin
            issue(rtype(1, 2, 11, 5, int'(fn[i])));
            tick();
            $display("txn b2b: R-format funct %0d", fn[i]);
            checks++; if (bus.Out_Valid !== 1'b1 || bus.Out_Ctrl !== exp[i]) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %0b/%h want 1/%h", i, bus.Out_Valid, bus.Out_Ctrl, exp[i]); end
            checks++; if (bus.Out_Illegal !== (i == 7)) begin errors++; $display("FAIL b2b_illegal[%0d]: got %0b want %0b", i, bus.Out_Illegal, (i == 7)); end
        end
        checks++; if (bus.Out_Shamt !== 5'd5) begin errors++; $display("FAIL shamt: got %0d want 5", bus.Out_Shamt); end
        idle();
        tick();
        checks++; if (bus.Out_Valid !== 1'b0 || bus.Out_Ctrl !== 12'h000) begin errors++; $display("FAIL idle: got %0b/%h want 0/000", bus.Out_Valid, bus.Out_Ctrl); end
    endtask

    task automatic test_reset_mid_stall();
        issue(itype(35, 1, 7, 16'd0));
        tick();
        issue(rtype(7, 2, 8, 0, 32));
        #1;
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL rms_stall: got %0b want 1", bus.Stall); end
        Rst_n = 1'b0;
        #1;
        $display("txn reset_mid_stall: reset while ADD r8,r7,r2 is held");
        checks++; if (bus.Stall !== 1'b0 || bus.In_Ready !== 1'b1 || bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL rms_clear: got s%0b r%0b v%0b want s0 r1 v0", bus.Stall, bus.In_Ready, bus.Out_Valid); end
        idle();
        #1 Rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst_n  = 1'b0;
        idle();
        repeat (2) @(posedge Clk);
        #1;
        test_reset();
        test_writeback();
        test_zero_reg();
        test_bypass();
        test_load_use();
        test_flush();
        test_imm_j_illegal();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
